// File: rtl/imsic_msi_tx.sv
`default_nettype none
// ============================================================================
// Module   : imsic_msi_tx
// Brief    : Bus-side MSI front end of the IMSIC. Validates seteipnum page
//            writes, queues legal MSIs, and serialises them onto the
//            msi_info / msi_info_vld level-pulse interface consumed by each
//            hart's asynchronous CSR gate.
// Revision : 1.0 - initial release
// ============================================================================
module imsic_msi_tx #(
  parameter int NR_INTP_FILES   = 7,
  parameter int NR_HARTS_WIDTH  = 2,
  parameter int NR_SRC          = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int HOLD_CYC        = 4,
  parameter int GAP_CYC         = 6,
  parameter int NR_SRC_WIDTH    = $clog2(NR_SRC),
  parameter int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  parameter int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
  parameter int ADDR_WIDTH      = 12 + INTP_FILE_WIDTH + NR_HARTS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_wr_vld,
  output logic                      s_wr_rdy,
  input  logic [ADDR_WIDTH-1:0]     s_wr_addr,
  input  logic [31:0]               s_wr_data,
  output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
  output logic                      o_msi_info_vld,
  output logic                      o_busy,
  output logic [7:0]                o_drop_cnt
);

  localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_max = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;
  localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [c_cnt_w-1:0]        w_cnt_nxt;
  logic                      w_pop;

  logic [MSI_INFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]        r_wptr;
  logic [c_ptr_w-1:0]        r_rptr;
  logic [c_ptr_w:0]          r_count;
  logic [MSI_INFO_WIDTH-1:0] r_info;

  logic [NR_HARTS_WIDTH-1:0]  w_hart;
  logic [INTP_FILE_WIDTH-1:0] w_file;
  logic                       w_legal;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_empty;

  // Address / data decode of the seteipnum page write
  assign w_hart   = s_wr_addr[12 + INTP_FILE_WIDTH +: NR_HARTS_WIDTH];
  assign w_file   = s_wr_addr[12 +: INTP_FILE_WIDTH];
  assign w_legal  = (s_wr_addr[11:0] == 12'd0)
                  && (32'(w_file) < 32'(NR_INTP_FILES))
                  && (s_wr_data != 32'd0)
                  && (s_wr_data < 32'(NR_SRC));

  // Ready depends only on the registered occupancy, never on s_wr_vld
  assign s_wr_rdy = (r_count != c_full);
  assign w_accept = s_wr_vld & s_wr_rdy;
  assign w_push   = w_accept & w_legal;
  assign w_drop   = w_accept & ~w_legal;
  assign w_empty  = (r_count == '0);
  assign o_busy   = ~w_empty | (r_state != ST_IDLE);

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_hart, w_file, s_wr_data[NR_SRC_WIDTH-1:0]};
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of accepted-but-illegal writes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_drop_cnt <= 8'd0;
    end else if (w_drop && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  // Pulse sequencer state, hold/gap counter, and the popped entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_info  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) r_info <= r_mem[r_rptr];
    end
  end

  // Next-state logic: pop on entry to HOLD, count HOLD then GAP cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_cnt_w'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = c_cnt_w'(GAP_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = c_cnt_w'(HOLD_CYC - 1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: vld mirrors HOLD one cycle later, info updates with it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_msi_info_vld <= 1'b0;
      o_msi_info     <= '0;
    end else begin
      o_msi_info_vld <= (r_state == ST_HOLD);
      o_msi_info     <= r_info;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imsic_msi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_imsic_msi_tx
// Brief    : Scoreboard bench for imsic_msi_tx with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imsic_msi_tx;

  localparam int HOLD_CYC = 4;
  localparam int GAP_CYC  = 6;

  logic        clk;
  logic        rstn;
  logic        s_wr_vld;
  logic        s_wr_rdy;
  logic [16:0] s_wr_addr;
  logic [31:0] s_wr_data;
  logic [9:0]  o_msi_info;
  logic        o_msi_info_vld;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rdy_low_seen = 0;

  logic [9:0] exp_q [$];
  int         rise_q[$];

  imsic_msi_tx #(
    .NR_INTP_FILES  (7),
    .NR_HARTS_WIDTH (2),
    .NR_SRC         (32),
    .FIFO_DEPTH     (4),
    .HOLD_CYC       (HOLD_CYC),
    .GAP_CYC        (GAP_CYC)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_wr_vld       (s_wr_vld),
    .s_wr_rdy       (s_wr_rdy),
    .s_wr_addr      (s_wr_addr),
    .s_wr_data      (s_wr_data),
    .o_msi_info     (o_msi_info),
    .o_msi_info_vld (o_msi_info_vld),
    .o_busy         (o_busy),
    .o_drop_cnt     (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter; read on negedges where it is stable
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Present one write at a negedge; returns at the negedge after acceptance
  task automatic wr(input logic [16:0] a, input logic [31:0] d, input int expv, output int acc);
    int w;
    w = 0;
    s_wr_vld  = 1'b1;
    s_wr_addr = a;
    s_wr_data = d;
    while (!s_wr_rdy && w < 100) begin
      rdy_low_seen = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!s_wr_rdy) begin
      checks++;
      errors++;
      $display("FAIL wr_rdy_timeout actual=0 required=1");
      s_wr_vld = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (expv >= 0) exp_q.push_back(10'(expv));
      @(negedge clk);
    end
  endtask

  // Monitor: pops expected info on each vld rise, checks hold/gap shape
  initial begin
    logic       prev_vld;
    logic [9:0] prev_info, rise_info, fall_info;
    int         hi_cnt, lo_cnt;
    bit         seen_fall;
    prev_vld = 0; prev_info = 0; rise_info = 0; fall_info = 0;
    hi_cnt = 0; lo_cnt = 0; seen_fall = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_vld = 0; prev_info = 0; hi_cnt = 0; lo_cnt = 0; seen_fall = 0;
      end else begin
        if (o_msi_info_vld && !prev_vld) begin
          if (seen_fall) begin
            chk("gap_len_min", 32'(lo_cnt >= GAP_CYC), 32'd1);
            chk("gap_info_frozen", 32'(prev_info), 32'(fall_info));
          end
          rise_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual=%0h required=none", o_msi_info);
          end else begin
            chk("msi_info", 32'(o_msi_info), 32'(exp_q.pop_front()));
          end
          rise_info = o_msi_info;
          hi_cnt = 1;
        end else if (o_msi_info_vld) begin
          hi_cnt++;
        end else if (prev_vld) begin
          chk("hold_len", 32'(hi_cnt), 32'(HOLD_CYC));
          chk("hold_info_stable", 32'(o_msi_info), 32'(rise_info));
          fall_info = o_msi_info;
          lo_cnt = 1;
          seen_fall = 1;
        end else begin
          lo_cnt++;
        end
        prev_vld  = o_msi_info_vld;
        prev_info = o_msi_info;
      end
    end
  end

  // Single legal write from idle: latency, pulse width, info freeze, no drops
  task automatic scen_default();
    int a;
    wr(17'h11000, 32'd5, 'h225, a);
    s_wr_vld = 1'b0;
    chk("lat_after_e_vld", 32'(o_msi_info_vld), 32'd0);
    @(negedge clk);
    chk("lat_after_e1_vld", 32'(o_msi_info_vld), 32'd0);
    @(negedge clk);
    chk("lat_after_e2_vld", 32'(o_msi_info_vld), 32'd1);
    chk("lat_after_e2_info", 32'(o_msi_info), 32'h225);
    wait_until(a + 2 + HOLD_CYC);
    chk("vld_fall", 32'(o_msi_info_vld), 32'd0);
    wait_until(a + 2 + HOLD_CYC + GAP_CYC - 1);
    chk("info_hold_in_gap", 32'(o_msi_info), 32'h225);
    wait_until(a + 14);
    chk("default_busy_idle", 32'(o_busy), 32'd0);
    chk("default_drop_cnt", 32'(o_drop_cnt), 32'd0);
  endtask

  logic [16:0] b_addr [6];
  logic [31:0] b_data [6];
  int          b_exp  [6];

  initial begin
    s_wr_vld  = 1'b0;
    s_wr_addr = '0;
    s_wr_data = '0;
    rstn      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vld",  32'(o_msi_info_vld), 32'd0);
    chk("reset_info", 32'(o_msi_info), 32'd0);
    chk("reset_drop", 32'(o_drop_cnt), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_rdy", 32'(s_wr_rdy), 32'd1);

    scen_default();

    // Illegal writes: zero id, id == NR_SRC, file 7, unaligned offset
    begin
      int a, c0;
      b_addr[0] = 17'h11000; b_data[0] = 32'd0;
      b_addr[1] = 17'h11000; b_data[1] = 32'd32;
      b_addr[2] = 17'h17000; b_data[2] = 32'd5;
      b_addr[3] = 17'h00004; b_data[3] = 32'd5;
      for (int i = 0; i < 4; i++) begin
        c0 = cyc;
        wr(b_addr[i], b_data[i], -1, a);
        chk("illegal_accept_immediate", 32'(a), 32'(c0 + 1));
      end
      s_wr_vld = 1'b0;
      repeat (15) @(negedge clk);
      chk("illegal_drop_cnt", 32'(o_drop_cnt), 32'd4);
      chk("illegal_busy", 32'(o_busy), 32'd0);
    end

    // Burst of six legal writes with vld held high
    begin
      int a, r;
      b_addr[0] = 17'h00000; b_data[0] = 32'd1;  b_exp[0] = 'h001;
      b_addr[1] = 17'h0B000; b_data[1] = 32'd7;  b_exp[1] = 'h167;
      b_addr[2] = 17'h1E000; b_data[2] = 32'd31; b_exp[2] = 'h3DF;
      b_addr[3] = 17'h12000; b_data[3] = 32'd16; b_exp[3] = 'h250;
      b_addr[4] = 17'h0D000; b_data[4] = 32'd9;  b_exp[4] = 'h1A9;
      b_addr[5] = 17'h04000; b_data[5] = 32'd2;  b_exp[5] = 'h082;
      rise_q.delete();
      rdy_low_seen = 1'b0;
      for (int i = 0; i < 6; i++) wr(b_addr[i], b_data[i], b_exp[i], a);
      s_wr_vld = 1'b0;
      chk("burst_rdy_deasserted", 32'(rdy_low_seen), 32'd1);
      for (int k = 0; k < 300 && rise_q.size() < 6; k++) @(negedge clk);
      chk("burst_pulse_count", 32'(rise_q.size()), 32'd6);
      for (int i = 1; i < rise_q.size(); i++)
        chk("burst_period", 32'(rise_q[i] - rise_q[i-1]), 32'(HOLD_CYC + GAP_CYC));
      if (rise_q.size() > 0) begin
        r = rise_q[rise_q.size() - 1];
        wait_until(r + 8);
        chk("burst_busy_in_gap", 32'(o_busy), 32'd1);
        wait_until(r + 10);
        chk("burst_busy_fall", 32'(o_busy), 32'd0);
      end
    end

    // Push landing on the pop edge at count 3, then fill, across pointer wrap
    begin
      int a, t;
      b_addr[0] = 17'h08000; b_data[0] = 32'd3;  b_exp[0] = 'h103;
      b_addr[1] = 17'h19000; b_data[1] = 32'd30; b_exp[1] = 'h33E;
      b_addr[2] = 17'h05000; b_data[2] = 32'd17; b_exp[2] = 'h0B1;
      b_addr[3] = 17'h16000; b_data[3] = 32'd12; b_exp[3] = 'h2CC;
      b_addr[4] = 17'h0A000; b_data[4] = 32'd21; b_exp[4] = 'h155;
      b_addr[5] = 17'h13000; b_data[5] = 32'd4;  b_exp[5] = 'h264;
      wr(b_addr[0], b_data[0], b_exp[0], a);
      for (int i = 1; i < 4; i++) wr(b_addr[i], b_data[i], b_exp[i], t);
      s_wr_vld = 1'b0;
      chk("pushpop_rdy_at_count3", 32'(s_wr_rdy), 32'd1);
      wait_until(a + HOLD_CYC + GAP_CYC);
      wr(b_addr[4], b_data[4], b_exp[4], t);
      chk("pushpop_accept_edge", 32'(t), 32'(a + HOLD_CYC + GAP_CYC + 1));
      chk("pushpop_count_kept", 32'(s_wr_rdy), 32'd1);
      wr(b_addr[5], b_data[5], b_exp[5], t);
      s_wr_vld = 1'b0;
      chk("pushpop_full_after", 32'(s_wr_rdy), 32'd0);
      for (int k = 0; k < 400 && (exp_q.size() != 0 || o_busy); k++) @(negedge clk);
      chk("pushpop_drained", 32'(exp_q.size()), 32'd0);
      chk("pushpop_busy", 32'(o_busy), 32'd0);
    end

    // Reset asserted during HOLD with more MSIs queued
    begin
      int a, t;
      wr(17'h11000, 32'd5, 'h225, a);
      wr(17'h0B000, 32'd7, 'h167, t);
      wr(17'h1E000, 32'd31, 'h3DF, t);
      s_wr_vld = 1'b0;
      wait_until(a + 3);
      chk("pre_reset_vld", 32'(o_msi_info_vld), 32'd1);
      rstn = 1'b0;
      exp_q.delete();
      #1;
      chk("midreset_vld",  32'(o_msi_info_vld), 32'd0);
      chk("midreset_info", 32'(o_msi_info), 32'd0);
      chk("midreset_rdy",  32'(s_wr_rdy), 32'd1);
      chk("midreset_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("postreset_busy", 32'(o_busy), 32'd0);
    end

    scen_default();

    // Drop counter saturation
    s_wr_vld  = 1'b1;
    s_wr_addr = 17'h11000;
    s_wr_data = 32'd0;
    repeat (100) @(negedge clk);
    chk("drop_cnt_100", 32'(o_drop_cnt), 32'd100);
    repeat (200) @(negedge clk);
    s_wr_vld = 1'b0;
    chk("drop_cnt_saturated", 32'(o_drop_cnt), 32'd255);
    repeat (15) @(negedge clk);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
